frame_buffer_2d: RTL
====================

Name: frame_buffer_2d

Overview:
- Parametrised, double-buffered 2-D pixel store; successor to the single-bank pixel buffer.
- Drawing logic writes into the back bank using (x, y) coordinates. The display scan-out reads the front bank with registered, 1-cycle-latency reads.
- Banks swap only at frame boundaries. A built-in clear engine fills the back bank with a constant colour.
- Out-of-range coordinates are rejected. Sits between the renderer and the VGA timing/scan-out path.

Parameters:
- DATA_WIDTH, 12, pixel width in bits (RGB444).
- X_WIDTH, 8, x coordinate width in bits.
- Y_WIDTH, 7, y coordinate width in bits.
- H_RES, 160, valid x range 0..H_RES-1; H_RES <= 2**X_WIDTH.
- V_RES, 120, valid y range 0..V_RES-1; V_RES <= 2**Y_WIDTH.
- CLEAR_VALUE, 12'h000, pixel value written by the clear engine.

Ports:
- clock, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- wr_en, in, 1, write strobe, back bank.
- wr_x, in, X_WIDTH, write x.
- wr_y, in, Y_WIDTH, write y.
- wr_data, in, DATA_WIDTH, write pixel.
- rd_en, in, 1, read strobe, front bank.
- rd_x, in, X_WIDTH, read x.
- rd_y, in, Y_WIDTH, read y.
- rd_data, out, DATA_WIDTH, registered read pixel.
- rd_valid, out, 1, high the cycle after an accepted rd_en.
- swap_req, in, 1, one-cycle pulse requesting a bank swap.
- frame_end, in, 1, one-cycle pulse at the vertical blank start.
- clear_req, in, 1, one-cycle pulse starting a back-bank clear.
- busy, out, 1, clear engine active.
- clear_done, out, 1, one-cycle pulse when a clear completes.
- front_sel, out, 1, index of the bank currently displayed.

Behaviour:
- Reset values, applied asynchronously on reset high:
  - rd_data=0, rd_valid=0, busy=0, clear_done=0, front_sel=0.
  - swap_pending=0, state=IDLE, clear counters=0.
  - Memory contents are not reset.
- Storage: 2 banks x 2**(X_WIDTH+Y_WIDTH) words. Address = {bank, y, x}. Back bank = ~front_sel.
- Write:
  - Accepted when wr_en=1, state=IDLE, wr_x<H_RES and wr_y<V_RES. Stored at the rising edge.
  - Otherwise the write is silently dropped.
- Read:
  - When rd_en=1, rd_data is updated at the next edge from the front bank, sampled at the request cycle. rd_valid=1 in that cycle.
  - An out-of-range read returns rd_data=0 with rd_valid=1.
  - When rd_en=0: rd_valid=0 next cycle and rd_data holds its value.
  - Reads are never blocked by busy.
- Read/write collision: reads and writes always target different banks, so there is no hazard.
- Swap:
  - swap_req sets swap_pending.
  - On frame_end with (swap_pending or swap_req in the same cycle) and state=IDLE: front_sel toggles at that edge and swap_pending clears.
  - A read issued in the toggle cycle uses the old front bank.
  - frame_end while CLEAR: the swap is deferred to the next frame_end after the clear finishes.
  - Repeated swap_req while pending has no extra effect.
- Clear FSM:
  - IDLE -> CLEAR on clear_req: busy=1 from the next edge.
  - CLEAR writes CLEAR_VALUE to the back bank, one pixel per cycle, raster order: x 0..H_RES-1 inner, y 0..V_RES-1 outer. This takes H_RES*V_RES cycles.
  - After writing (H_RES-1, V_RES-1): -> IDLE, busy=0, clear_done=1 for one cycle.
  - clear_req while CLEAR is ignored.
  - wr_en while CLEAR is dropped.
  - clear_req and wr_en in the same IDLE cycle: the write is accepted and the clear starts next cycle.
  - Reset mid-clear aborts the clear: IDLE, counters=0, no clear_done.
- Counters sized X_WIDTH/Y_WIDTH and compared against H_RES-1/V_RES-1 exactly. No wrap past the valid range.

Optional Feature:
- Macro: FRAME_BUFFER_STATS_EN.
- Defined: adds output drop_count (16 bits).
  - Increments once per dropped wr_en, whether out of range or while busy. Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset, then write (3,5)=12'hABC, swap_req and frame_end -> front_sel=1; rd_en at (3,5) -> next cycle rd_valid=1, rd_data=12'hABC.
- Write (160,0) and (0,120) with default params -> both dropped; after swap, reads return the prior contents. Read (200,10) -> rd_data=0, rd_valid=1. With STATS_EN, drop_count=2.
- clear_req with CLEAR_VALUE=12'h00F -> busy high for 19200 cycles, then a single clear_done pulse. After swap, reads at (0,0) and (159,119) return 12'h00F. A wr_en during busy has no effect.
- swap_req, then frame_end during a clear -> front_sel unchanged. The first frame_end after clear_done toggles it.
- Assert reset at cycle 100 of a clear -> busy=0 immediately, no clear_done. A new clear_req restarts from (0,0).
- Read (3,5) in the same cycle frame_end toggles front_sel -> returns old-front data. The following read returns new-front data.

Source files
------------

// File: rtl/frame_buffer_2d_if.sv
// Renderer/scan-out bus of the double-buffered 2-D frame buffer.
// FRAME_BUFFER_STATS_EN adds the drop_count statistics output.
interface frame_buffer_2d_if #(
    parameter int DATA_WIDTH = 12,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7
) ();
    logic                  wr_en;
    logic [X_WIDTH-1:0]    wr_x;
    logic [Y_WIDTH-1:0]    wr_y;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [X_WIDTH-1:0]    rd_x;
    logic [Y_WIDTH-1:0]    rd_y;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  swap_req;
    logic                  frame_end;
    logic                  clear_req;
    logic                  busy;
    logic                  clear_done;
    logic                  front_sel;
`ifdef FRAME_BUFFER_STATS_EN
    logic [15:0]           drop_count;
`endif

    modport master (
        output wr_en, wr_x, wr_y, wr_data,
        output rd_en, rd_x, rd_y,
        output swap_req, frame_end, clear_req,
        input  rd_data, rd_valid, busy, clear_done, front_sel
`ifdef FRAME_BUFFER_STATS_EN
        , input drop_count
`endif
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_data,
        input  rd_en, rd_x, rd_y,
        input  swap_req, frame_end, clear_req,
        output rd_data, rd_valid, busy, clear_done, front_sel
`ifdef FRAME_BUFFER_STATS_EN
        , output drop_count
`endif
    );
endinterface

// File: rtl/frame_buffer_2d.sv
// Double-buffered 2-D pixel store with frame-synchronous bank swap and a back-bank clear engine.
// Optional FRAME_BUFFER_STATS_EN adds a saturating count of dropped writes.
module frame_buffer_2d #(
    parameter int                    DATA_WIDTH  = 12,
    parameter int                    X_WIDTH     = 8,
    parameter int                    Y_WIDTH     = 7,
    parameter int                    H_RES       = 160,
    parameter int                    V_RES       = 120,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = 12'h000
) (
    input  logic              clock,
    input  logic              reset,
    frame_buffer_2d_if.slave  bus
);

    localparam int ADDR_WIDTH = 1 + Y_WIDTH + X_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    // Limits carry one spare bit so H_RES == 2**X_WIDTH still compares correctly.
    localparam logic [X_WIDTH:0]   H_LIMIT = (X_WIDTH + 1)'(H_RES);
    localparam logic [Y_WIDTH:0]   V_LIMIT = (Y_WIDTH + 1)'(V_RES);
    localparam logic [X_WIDTH-1:0] X_LAST  = X_WIDTH'(H_RES - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(V_RES - 1);
    localparam logic [X_WIDTH-1:0] X_ZERO  = {X_WIDTH{1'b0}};
    localparam logic [Y_WIDTH-1:0] Y_ZERO  = {Y_WIDTH{1'b0}};
    localparam logic [X_WIDTH-1:0] X_ONE   = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE   = Y_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [X_WIDTH-1:0]    clr_x_r;
    logic [X_WIDTH-1:0]    clr_x_s;
    logic [Y_WIDTH-1:0]    clr_y_r;
    logic [Y_WIDTH-1:0]    clr_y_s;
    logic                  clr_last_s;
    logic                  clear_done_s;
    logic                  busy_r;
    logic                  clear_done_r;
    logic                  front_sel_r;
    logic                  swap_pending_r;
    logic                  swap_fire_s;
    logic                  wr_accept_s;
    logic                  rd_in_range_s;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Qualify user writes, scan-out reads, swaps and the final clear pixel.
    always_comb begin
        wr_accept_s   = 1'b0;
        rd_in_range_s = 1'b0;
        swap_fire_s   = 1'b0;
        clr_last_s    = 1'b0;
        if (bus.wr_en && (state_r == ST_IDLE) &&
            ({1'b0, bus.wr_x} < H_LIMIT) && ({1'b0, bus.wr_y} < V_LIMIT)) begin
            wr_accept_s = 1'b1;
        end else begin
            wr_accept_s = 1'b0;
        end
        if (({1'b0, bus.rd_x} < H_LIMIT) && ({1'b0, bus.rd_y} < V_LIMIT)) begin
            rd_in_range_s = 1'b1;
        end else begin
            rd_in_range_s = 1'b0;
        end
        if (bus.frame_end && (swap_pending_r || bus.swap_req) && (state_r == ST_IDLE)) begin
            swap_fire_s = 1'b1;
        end else begin
            swap_fire_s = 1'b0;
        end
        if ((clr_x_r == X_LAST) && (clr_y_r == Y_LAST)) begin
            clr_last_s = 1'b1;
        end else begin
            clr_last_s = 1'b0;
        end
    end

    // Clear FSM next state and raster counter advance.
    always_comb begin
        state_s      = state_r;
        clr_x_s      = clr_x_r;
        clr_y_s      = clr_y_r;
        clear_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_s = ST_CLEAR;
                    clr_x_s = X_ZERO;
                    clr_y_s = Y_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_s      = ST_IDLE;
                    clr_x_s      = X_ZERO;
                    clr_y_s      = Y_ZERO;
                    clear_done_s = 1'b1;
                end else if (clr_x_r == X_LAST) begin
                    clr_x_s = X_ZERO;
                    clr_y_s = clr_y_r + Y_ONE;
                end else begin
                    clr_x_s = clr_x_r + X_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                clr_x_s = X_ZERO;
                clr_y_s = Y_ZERO;
            end
        endcase
    end

    // FSM state, counters and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            clr_x_r      <= X_ZERO;
            clr_y_r      <= Y_ZERO;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            clr_x_r      <= clr_x_s;
            clr_y_r      <= clr_y_s;
            busy_r       <= (state_s == ST_CLEAR);
            clear_done_r <= clear_done_s;
        end
    end

    // Bank swap: a request is held until a frame boundary seen while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front_sel_r    <= 1'b0;
            swap_pending_r <= 1'b0;
        end else if (swap_fire_s) begin
            front_sel_r    <= ~front_sel_r;
            swap_pending_r <= 1'b0;
        end else if (bus.swap_req) begin
            swap_pending_r <= 1'b1;
        end
    end

    // Single write port into the back bank, shared by the clear engine and the renderer.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {~front_sel_r, bus.wr_y, bus.wr_x};
        mem_wdata_s = bus.wr_data;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = {~front_sel_r, clr_y_r, clr_x_r};
            mem_wdata_s = CLEAR_VALUE;
        end else if (wr_accept_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = {~front_sel_r, bus.wr_y, bus.wr_x};
            mem_wdata_s = bus.wr_data;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Pixel storage; contents deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Registered front-bank read; the bank is sampled before any swap at the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (bus.rd_en) begin
            rd_valid_r <= 1'b1;
            if (rd_in_range_s) begin
                rd_data_r <= mem_r[{front_sel_r, bus.rd_y, bus.rd_x}];
            end else begin
                rd_data_r <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

`ifdef FRAME_BUFFER_STATS_EN
    logic [15:0] drop_count_r;

    // Saturating count of write strobes that were not stored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_r <= 16'h0000;
        end else if (bus.wr_en && !wr_accept_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end
    end

    assign bus.drop_count = drop_count_r;
`endif

    assign bus.rd_data    = rd_data_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.busy       = busy_r;
    assign bus.clear_done = clear_done_r;
    assign bus.front_sel  = front_sel_r;

endmodule
